// File: rtl/sobel_window_3x3.sv
// rtl/sobel_window_3x3.sv - 3x3 pixel window assembler for the Sobel stage
//
// Takes three row-aligned pixel columns from the double line buffer and
// shifts them into a 3x3 window. Tracks column/row position so that only
// in-frame windows (row >= 2, col >= 2) are flagged valid, and pulses
// frame_done_o with the last window of each frame.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   valid_i            one pixel column present on data*_i this cycle
//   data0_i            current row pixel (newest)
//   data1_i            previous row pixel, same column
//   data2_i            pixel two rows back, same column (oldest)
//   p00_o..p22_o       window, row 0 = oldest row, column 2 = newest column
//   valid_o            window outputs hold a complete in-frame 3x3 window
//   frame_done_o       one-cycle pulse with the last window of the frame
//   busy_o             frame in progress

module sobel_window_3x3 #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] data0_i,
    input  logic [7:0] data1_i,
    input  logic [7:0] data2_i,
    output logic [7:0] p00_o,
    output logic [7:0] p01_o,
    output logic [7:0] p02_o,
    output logic [7:0] p10_o,
    output logic [7:0] p11_o,
    output logic [7:0] p12_o,
    output logic [7:0] p20_o,
    output logic [7:0] p21_o,
    output logic [7:0] p22_o,
    output logic       valid_o,
    output logic       frame_done_o,
    output logic       busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          col_last;
    logic          row_last;
    logic          win_ok;

    assign col_last = (col_cnt == COL_LAST);
    assign row_last = (row_cnt == ROW_LAST);
    // Columns 0/1 still hold the previous line's tail, rows 0/1 lack history.
    assign win_ok   = (row_cnt >= ROW_TWO) && (col_cnt >= COL_TWO);
    assign busy_o   = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (valid_i) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (valid_i && col_last && (row_cnt == ROW_ONE)) begin
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (valid_i && col_last && row_last) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                // DONE lasts exactly one cycle; a pixel arriving here is
                // already column 0 / row 0 of the next frame.
                state_nxt = valid_i ? S_FILL : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (valid_i) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            valid_o      <= valid_i && win_ok;
            frame_done_o <= valid_i && col_last && row_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p00_o <= '0;
            p01_o <= '0;
            p02_o <= '0;
            p10_o <= '0;
            p11_o <= '0;
            p12_o <= '0;
            p20_o <= '0;
            p21_o <= '0;
            p22_o <= '0;
        end else if (valid_i) begin
            p00_o <= p01_o;
            p01_o <= p02_o;
            p02_o <= data2_i;
            p10_o <= p11_o;
            p11_o <= p12_o;
            p12_o <= data1_i;
            p20_o <= p21_o;
            p21_o <= p22_o;
            p22_o <= data0_i;
        end
    end

endmodule

// File: tb/tb_sobel_window_3x3.sv
// tb/tb_sobel_window_3x3.sv - scoreboard bench for sobel_window_3x3
module tb_sobel_window_3x3;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data0_i = '0;
    logic [7:0] data1_i = '0;
    logic [7:0] data2_i = '0;
    logic [7:0] p00_o, p01_o, p02_o, p10_o, p11_o, p12_o, p20_o, p21_o, p22_o;
    logic       valid_o, frame_done_o, busy_o;

    sobel_window_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .data0_i      (data0_i),
        .data1_i      (data1_i),
        .data2_i      (data2_i),
        .p00_o        (p00_o),
        .p01_o        (p01_o),
        .p02_o        (p02_o),
        .p10_o        (p10_o),
        .p11_o        (p11_o),
        .p12_o        (p12_o),
        .p20_o        (p20_o),
        .p21_o        (p21_o),
        .p22_o        (p22_o),
        .valid_o      (valid_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic        ed;
        logic [71:0] w;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   win_cnt  = 0;
    int   done_cnt = 0;
    logic acc_prev = 1'b0;
    logic [71:0] win;

    assign win = {p00_o, p01_o, p02_o, p10_o, p11_o, p12_o, p20_o, p21_o, p22_o};

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] x;
        x = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                x = {x[63:0], 8'((r - 2 + i) * W + (c - 2 + j))};
            end
        end
        return x;
    endfunction

    // Which pixel the DUT took at the last rising edge.
    always @(posedge clk) acc_prev <= valid_i && !rst;

    always @(negedge clk) begin
        if (!rst) begin
            if (acc_prev) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("valid_o", valid_o, e.ev);
                    check("frame_done_o", frame_done_o, e.ed);
                    if (e.ev) check("window", win, e.w);
                end
            end else begin
                check("valid_after_idle", valid_o, 0);
                check("done_after_idle", frame_done_o, 0);
            end
            if (valid_o) win_cnt++;
            if (frame_done_o) done_cnt++;
        end
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        data0_i = 8'($urandom);
        data1_i = 8'($urandom);
        data2_i = 8'($urandom);
    endtask

    task automatic drive_pixel(input int r, input int c);
        exp_t x;
        int   v;
        @(posedge clk);
        #1;
        v = r * W + c;
        valid_i = 1'b1;
        data0_i = 8'(v);
        data1_i = 8'(v - W);
        data2_i = 8'(v - 2 * W);
        x.ev = (r >= 2) && (c >= 2);
        x.ed = (r == H - 1) && (c == W - 1);
        x.w  = exp_win(r, c);
        sb.push_back(x);
        if (r == 1 && c == 0) check("busy_mid_frame", busy_o, 1);
    endtask

    task automatic drive_frame(input int gap_pct);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(99) < gap_pct) idle_cycle();
                drive_pixel(r, c);
            end
        end
    endtask

    task automatic drain_and_count(input string tag, input int wins, input int dones);
        repeat (4) idle_cycle();
        check({tag, "_windows"}, win_cnt, wins);
        check({tag, "_dones"}, done_cnt, dones);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_busy_end"}, busy_o, 0);
        win_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_window"}, win, 0);
        check({tag, "_valid"}, valid_o, 0);
        check({tag, "_done"}, frame_done_o, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        // Reset held with input activity.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            valid_i = 1'($urandom);
            data0_i = 8'($urandom);
            data1_i = 8'($urandom);
            data2_i = 8'($urandom);
            @(negedge clk);
            if (i % 2 == 0) check_cleared("reset_hold");
        end
        idle_cycle();
        @(negedge clk);
        #2 rst = 1'b0;
        check("reset_col_cnt", 32'(dut.col_cnt), 0);
        check("reset_row_cnt", 32'(dut.row_cnt), 0);
        check_cleared("after_release");

        drive_frame(0);
        drain_and_count("frame", 6, 1);

        drive_frame(50);
        drain_and_count("gapped", 6, 1);

        drive_frame(0);
        drive_frame(0);
        drain_and_count("b2b", 12, 2);

        // Abort in row 2: the (2,3) pixel is presented but reset lands first.
        for (int c = 0; c < W; c++) drive_pixel(0, c);
        for (int c = 0; c < W; c++) drive_pixel(1, c);
        for (int c = 0; c < 3; c++) drive_pixel(2, c);
        drive_pixel(2, 3);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_cleared("async_reset");
        valid_i = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        win_cnt  = 0;
        done_cnt = 0;
        check("abort_col_cnt", 32'(dut.col_cnt), 0);
        check("abort_row_cnt", 32'(dut.row_cnt), 0);

        drive_frame(0);
        drain_and_count("post_reset", 6, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
